// File: rtl/uart_bridge_if.sv
// Core-side byte handshake between the processor and the UART bridge.
// The core is the master; the bridge answers on the slave modport.
interface uart_bridge_if;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;
  logic       uart_out_valid;
  logic [7:0] uart_out_data;
  logic       uart_out_ready;

  modport master (
    output uart_in_data, uart_in_valid, uart_out_valid,
    input  uart_in_ready, uart_out_data, uart_out_ready
  );

  modport slave (
    input  uart_in_data, uart_in_valid, uart_out_valid,
    output uart_in_ready, uart_out_data, uart_out_ready
  );
endinterface

// File: rtl/uart_bridge.sv
// Byte-level 8N1 UART endpoint with TX and RX FIFOs between the core handshake
// and the board pins.
module uart_bridge #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic         clk,
  input  logic         reset,
  uart_bridge_if.slave bus,
  output logic         txd,
  input  logic         rxd,
  output logic         rx_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [AW:0] r_tx_wptr, r_tx_rptr;
  logic [7:0]  r_rx_mem [FIFO_DEPTH];
  logic [AW:0] r_rx_wptr, r_rx_rptr;
  logic        w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic        w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_drop;

  logic        r_in_ready, r_out_ready;
  logic [7:0]  r_out_data;

  tx_state_t   r_tx_state, w_tx_state_next;
  logic [CW-1:0] r_tx_baud;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        w_tx_bit_end;

  rx_state_t   r_rx_state, w_rx_state_next;
  logic        r_rx_sync1, r_rx_sync2, w_rxs;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_ovf, w_rx_tick, w_rx_tick_half;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[AW] != r_tx_rptr[AW]) && (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[AW] != r_rx_rptr[AW]) && (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);

  assign w_tx_push = bus.uart_in_valid && !r_in_ready && !w_tx_full;
  assign w_rx_pop  = bus.uart_out_valid && !r_out_ready && !w_rx_empty;

  assign bus.uart_in_ready  = r_in_ready;
  assign bus.uart_out_ready = r_out_ready;
  assign bus.uart_out_data  = r_out_data;
  assign rx_overflow        = r_rx_ovf;
  assign txd = (r_tx_state == TX_START) ? 1'b0 :
               (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[AW-1:0]] <= bus.uart_in_data;
    if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wptr   <= '0;
      r_tx_rptr   <= '0;
      r_rx_wptr   <= '0;
      r_rx_rptr   <= '0;
      r_in_ready  <= 1'b0;
      r_out_ready <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_in_ready  <= w_tx_push;
      r_out_ready <= w_rx_pop;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_ONE;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
      if (w_rx_pop) begin
        r_rx_rptr  <= r_rx_rptr + PTR_ONE;
        r_out_data <= r_rx_mem[r_rx_rptr[AW-1:0]];
      end
    end
  end

  assign w_tx_bit_end = (r_tx_baud == BIT_LAST);

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_pop        = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (!w_tx_empty) begin
        w_tx_state_next = TX_START;
        w_tx_pop        = 1'b1;
      end
      TX_START: if (w_tx_bit_end) w_tx_state_next = TX_DATA;
      TX_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_state_next = TX_STOP;
      TX_STOP: if (w_tx_bit_end) begin
        // Chain straight into the next frame so queued bytes leave no idle gap.
        if (!w_tx_empty) begin
          w_tx_state_next = TX_START;
          w_tx_pop        = 1'b1;
        end else begin
          w_tx_state_next = TX_IDLE;
        end
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_state_next;
      if (r_tx_state == TX_IDLE || w_tx_bit_end) r_tx_baud <= '0;
      else r_tx_baud <= r_tx_baud + CNT_ONE;
      if (w_tx_pop) begin
        r_tx_shift <= r_tx_mem[r_tx_rptr[AW-1:0]];
        r_tx_bit   <= '0;
      end else if (r_tx_state == TX_DATA && w_tx_bit_end) begin
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
        r_tx_bit   <= r_tx_bit + 3'd1;
      end
    end
  end

  assign w_rxs          = r_rx_sync2;
  assign w_rx_tick      = (r_rx_cnt == BIT_LAST);
  assign w_rx_tick_half = (r_rx_cnt == HALF_LAST);

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_push       = 1'b0;
    w_rx_drop       = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (!w_rxs) w_rx_state_next = RX_START;
      RX_START: if (w_rx_tick_half) w_rx_state_next = w_rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_state_next = RX_STOP;
      RX_STOP: if (w_rx_tick) begin
        if (w_rxs) begin
          w_rx_state_next = RX_IDLE;
          w_rx_push       = !w_rx_full;
          w_rx_drop       = w_rx_full;
        end else begin
          w_rx_state_next = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (w_rxs) w_rx_state_next = RX_IDLE;
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_ovf   <= 1'b0;
    end else begin
      r_rx_sync1 <= rxd;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_state <= w_rx_state_next;
      if (r_rx_state == RX_IDLE || w_rx_state_next != r_rx_state || w_rx_tick) r_rx_cnt <= '0;
      else r_rx_cnt <= r_rx_cnt + CNT_ONE;
      if (r_rx_state == RX_START) begin
        r_rx_bit <= '0;
      end else if (r_rx_state == RX_DATA && w_rx_tick) begin
        r_rx_shift <= {w_rxs, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
      if (w_rx_drop) r_rx_ovf <= 1'b1;
    end
  end
endmodule
